// File: rtl/mips_multicycle_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath (or a bench) uses slave.
interface mips_multicycle_controller_if;
    logic [5:0] opc;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       RegDst;
    logic       AluSrcA;
    logic [1:0] PCSource;
    logic [1:0] AluSrcB;
    logic [1:0] AluOp;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  opc, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, AluSrcA, PCSource, AluSrcB,
               AluOp, IllegalOp, State
    );

    modport slave (
        output opc, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, AluSrcA, PCSource, AluSrcB,
               AluOp, IllegalOp, State
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Build option: define IMM_ARITH_EN to add the addi/slti path (IEXEC/IWB).
//
// state  | meaning
// FETCH  | read instruction, PC+4 (waits on MemReady)
// DECODE | register read, branch target into ALUOut
// MEMADR | effective address for lw/sw
// MEMRD  | data read (waits on MemReady)
// MEMWB  | load result to register file
// MEMWR  | data write (waits on MemReady)
// EXEC   | R-type ALU operation
// RWB    | R-type result to rd
// BRANCH | beq compare, conditional PC update
// JUMP   | PC <- jump address
// IEXEC  | addi/slti ALU operation
// IWB    | immediate result to rt
module mips_multicycle_controller (
    input logic                          clk,
    input logic                          rst,
    mips_multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t     state, state_next;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_dbg;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        illegal_op    = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        state_dbg     = state;

        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                // IR and PC update only on the cycle memory delivers the word
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
                state_next = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opc)
                    OP_RTYPE:      state_next = S_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
`ifdef IMM_ARITH_EN
                    OP_ADDI, OP_SLTI: state_next = S_IEXEC;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (bus.opc == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                state_next = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                state_next = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef IMM_ARITH_EN
            S_IEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (bus.opc == OP_SLTI) ? 2'b11 : 2'b00;
                state_next = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
`endif
            default: begin
                state_dbg  = 4'd0;
                state_next = S_FETCH;
            end
        endcase

        // Reset blanks every strobe so no write can complete while held
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            illegal_op    = 1'b0;
            pc_source     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            state_dbg     = 4'd0;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = reg_dst;
    assign bus.AluSrcA     = alu_src_a;
    assign bus.PCSource    = pc_source;
    assign bus.AluSrcB     = alu_src_b;
    assign bus.AluOp       = alu_op;
    assign bus.IllegalOp   = illegal_op;
    assign bus.State       = state_dbg;

endmodule
